// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC conversion scheduler.
package adc_sched_pkg;

    localparam int unsigned CFG_W = 16;
    localparam int unsigned RES_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CONVERT,
        CAPTURE,
        NEXT,
        WAIT
    } state_t;

    // A zero period would never expire; treat it as back-to-back sweeps.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/adc_chan_pick.sv
// Finds the lowest set mask bit, either overall or strictly above the current slot.
module adc_chan_pick #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CW-1:0]     cur,
    input  logic              from_start,
    output logic [CW-1:0]     idx,
    output logic              found
);

    // Scan downwards so the lowest qualifying slot is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur)))) begin
                found = 1'b1;
                idx   = CW'(i);
            end
        end
    end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Sweeps enabled channels through adc_core_digital, one conversion per slot,
// and hands each result to a valid/ready output register.
module adc_conv_scheduler
    import adc_sched_pkg::*;
#(
    parameter  int unsigned NUM_CH         = 4,
    parameter  int unsigned SETTLE_CYCLES  = 2,
    parameter  int unsigned TIMEOUT_CYCLES = 2047,
    parameter  int unsigned PERIOD_W       = 16,
    localparam int unsigned CW             = $clog2(NUM_CH)
) (
    input  logic                    clk_dig_in,
    input  logic                    rst,
    input  logic                    enable_in,
    input  logic                    continuous_in,
    input  logic                    trigger_in,
    input  logic [PERIOD_W-1:0]     period_in,
    input  logic [NUM_CH-1:0]       chan_mask_in,
    input  logic [CFG_W*NUM_CH-1:0] chan_cfg_in,
    input  logic                    clear_err_in,
    output logic                    core_rst_n_out,
    output logic [CFG_W-1:0]        core_config_1_out,
    output logic [CW-1:0]           chan_sel_out,
    input  logic                    core_conv_finished_osr_in,
    input  logic [RES_W-1:0]        core_result_in,
    output logic [RES_W-1:0]        result_out,
    output logic [CW-1:0]           result_chan_out,
    output logic                    result_valid_out,
    input  logic                    result_ready_in,
    output logic                    busy_out,
    output logic                    overrun_out,
    output logic                    timeout_out
);

    localparam int unsigned CNT_W = 16;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PERIOD_W-1:0]     period_q, period_d;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic [CFG_W*NUM_CH-1:0] cfg_q, cfg_d;
    logic                    fin_q;
    logic [CW-1:0]           chan_sel_d;
    logic [CFG_W-1:0]        cfg_out_d;
    logic [RES_W-1:0]        res_d;
    logic [CW-1:0]           res_chan_d;
    logic                    valid_d, busy_d, rst_n_d, ovr_d, to_d;
    logic                    capture, ovr_set, to_set;

    logic [NUM_CH-1:0]       pick_mask;
    logic [CFG_W*NUM_CH-1:0] cfg_src;
    logic [CW-1:0]           pick_idx;
    logic                    pick_found, pick_from_start;
    logic [CFG_W-1:0]        pick_cfg;
    logic                    fin_rise, expired, start;

    // Outside NEXT the finder looks at the live mask for a fresh sweep.
    assign pick_from_start = (state_q != NEXT);
    assign pick_mask       = pick_from_start ? chan_mask_in : mask_q;
    assign cfg_src         = pick_from_start ? chan_cfg_in : cfg_q;
    assign pick_cfg        = cfg_src[int'(pick_idx)*CFG_W +: CFG_W];

    assign fin_rise = core_conv_finished_osr_in && !fin_q;
    assign expired  = (period_q <= PERIOD_W'(1));
    assign start    = enable_in && (chan_mask_in != '0) &&
                      (((state_q == IDLE) && (trigger_in || continuous_in)) ||
                       ((state_q == WAIT) && continuous_in && expired));

    adc_chan_pick #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_pick (
        .mask       (pick_mask),
        .cur        (chan_sel_out),
        .from_start (pick_from_start),
        .idx        (pick_idx),
        .found      (pick_found)
    );

    always_ff @(posedge clk_dig_in or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            period_q          <= '0;
            mask_q            <= '0;
            cfg_q             <= '0;
            fin_q             <= 1'b0;
            chan_sel_out      <= '0;
            core_config_1_out <= '0;
            core_rst_n_out    <= 1'b0;
            result_out        <= '0;
            result_chan_out   <= '0;
            result_valid_out  <= 1'b0;
            busy_out          <= 1'b0;
            overrun_out       <= 1'b0;
            timeout_out       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            period_q          <= period_d;
            mask_q            <= mask_d;
            cfg_q             <= cfg_d;
            fin_q             <= core_conv_finished_osr_in;
            chan_sel_out      <= chan_sel_d;
            core_config_1_out <= cfg_out_d;
            core_rst_n_out    <= rst_n_d;
            result_out        <= res_d;
            result_chan_out   <= res_chan_d;
            result_valid_out  <= valid_d;
            busy_out          <= busy_d;
            overrun_out       <= ovr_d;
            timeout_out       <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = (period_q != '0) ? period_q - PERIOD_W'(1) : '0;
        mask_d     = mask_q;
        cfg_d      = cfg_q;
        chan_sel_d = chan_sel_out;
        cfg_out_d  = core_config_1_out;
        res_d      = result_out;
        res_chan_d = result_chan_out;
        capture    = 1'b0;
        ovr_set    = 1'b0;
        to_set     = 1'b0;

        if (!enable_in) begin
            state_d  = IDLE;
            cnt_d    = '0;
            period_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                SETUP: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = CONVERT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CONVERT: begin
                    if (fin_rise) begin
                        cnt_d   = '0;
                        state_d = CAPTURE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cnt_d   = '0;
                        to_set  = 1'b1;
                        state_d = NEXT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    res_d      = core_result_in;
                    res_chan_d = chan_sel_out;
                    capture    = 1'b1;
                    ovr_set    = result_valid_out && !result_ready_in;
                    state_d    = NEXT;
                end
                NEXT: begin
                    if (pick_found) begin
                        chan_sel_d = pick_idx;
                        cfg_out_d  = pick_cfg;
                        cnt_d      = '0;
                        state_d    = SETUP;
                    end else begin
                        state_d = continuous_in ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    if (!continuous_in) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (start) begin
                mask_d     = chan_mask_in;
                cfg_d      = chan_cfg_in;
                period_d   = PERIOD_W'(clamp_period(32'(period_in)));
                chan_sel_d = pick_idx;
                cfg_out_d  = pick_cfg;
                cnt_d      = '0;
                state_d    = SETUP;
            end
        end

        valid_d = capture || (result_valid_out && !result_ready_in);
        ovr_d   = ovr_set || (overrun_out && !clear_err_in);
        to_d    = to_set || (timeout_out && !clear_err_in);
        rst_n_d = (state_d == CONVERT);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: doc/adc_conv_scheduler.md
Name: adc_conv_scheduler

Overview:
Sequencer placed in front of adc_core_digital. It sweeps up to four analog input channels, either once per trigger or continuously at a programmed period. For each enabled channel it:
- applies that channel's averaging/OSR config word;
- pulses the core's reset to start a fresh conversion;
- waits for the core's OSR-complete flag;
- captures the 10-bit result into a valid/ready output register tagged with the channel number.

Parameters:
NUM_CH, 4, number of channel slots (2..8); channel index width CW = clog2(NUM_CH)
SETTLE_CYCLES, 2, cycles core reset is held low after mux/config change (>=1)
TIMEOUT_CYCLES, 2047, max cycles waiting for core completion before abort
PERIOD_W, 16, width of sweep-period counter

Ports:
clk_dig_in  in  1  digital clock, same as core
rst  in  1  asynchronous active-high reset
enable_in  in  1  scheduler enable; low aborts activity
continuous_in  in  1  1 = repeat sweeps every period_in cycles; 0 = single sweep per trigger
trigger_in  in  1  single-cycle pulse starting one sweep (single mode)
period_in  in  PERIOD_W  cycles between sweep starts (continuous)
chan_mask_in  in  NUM_CH  channel enable mask
chan_cfg_in  in  16*NUM_CH  per-channel config_1 word, slot i at [16i+15:16i]
clear_err_in  in  1  clears sticky flags
core_rst_n_out  out  1  drives core rst_n
core_config_1_out  out  16  drives core config_1_in
chan_sel_out  out  CW  analog input mux select
core_conv_finished_osr_in  in  1  core OSR-complete flag
core_result_in  in  10  core result_out
result_out  out  10  captured result
result_chan_out  out  CW  channel of captured result
result_valid_out  out  1  output register holds unread data
result_ready_in  in  1  consumer accepts when valid && ready
busy_out  out  1  high in any state other than IDLE
overrun_out  out  1  sticky: unread result overwritten
timeout_out  out  1  sticky: conversion timed out

Behaviour:
Reset values:
- core_rst_n_out=0; core_config_1_out=0; chan_sel_out=0.
- result_out=0; result_chan_out=0; result_valid_out=0.
- busy_out=0; overrun_out=0; timeout_out=0. FSM in IDLE.

FSM states and transitions:
- IDLE: core_rst_n_out=0.
  - Sweep starts when enable_in && chan_mask_in!=0 && (trigger_in || continuous_in).
  - At sweep start, latch chan_mask_in, chan_cfg_in, period_in; select the lowest set mask bit; load the period counter; go to SETUP.
  - mask==0: remain in IDLE; trigger is ignored.
- SETUP: drive chan_sel_out and core_config_1_out for the current slot; hold core_rst_n_out=0 for exactly SETTLE_CYCLES cycles, then go to CONVERT.
- CONVERT: core_rst_n_out=1.
  - Rising edge of core_conv_finished_osr_in (registered previous value) -> CAPTURE.
  - A level already high on entry does not count.
  - Wait counter reaching TIMEOUT_CYCLES -> set timeout_out, skip CAPTURE, go to NEXT.
- CAPTURE, 1 cycle:
  - Load result_out<=core_result_in, result_chan_out<=slot, result_valid_out<=1.
  - If result_valid_out was already 1 and no handshake occurs this cycle, set overrun_out; the newer data wins.
  - Core_rst_n_out returns to 0 here. Go to NEXT.
- NEXT, 1 cycle: find the next set latched-mask bit above the current slot.
  - Found -> SETUP.
  - Not found, single mode -> IDLE.
  - Not found, continuous mode -> WAIT.
- WAIT: core_rst_n_out=0. When the period counter expires, re-latch mask/cfg/period and go to SETUP (lowest slot).
  - If the counter already expired during the sweep (sweep longer than period), the next sweep starts on the cycle after NEXT; no error is raised.
  - continuous_in low while in WAIT -> IDLE.

Counters:
- The period counter runs from each sweep start, decrementing freely. It saturates at 0.
- period_in==0 is treated as 1 (back-to-back sweeps).

Output handshake:
- valid && ready -> result_valid_out clears next cycle.
- If a handshake and CAPTURE coincide, result_valid_out stays 1 with the new data, and overrun is not set.

Abort and error flags:
- enable_in low in any state: next cycle goes to IDLE, core_rst_n_out=0, counters cleared. The result register and its valid bit are preserved.
- trigger_in while busy is ignored.
- clear_err_in clears overrun_out and timeout_out. If it coincides with a new set event, the set wins.

Decomposition:
- Package adc_sched_pkg:
  - state enum {IDLE, SETUP, CONVERT, CAPTURE, NEXT, WAIT};
  - CFG_W=16, RES_W=10 constants;
  - helper function for the period==0 -> 1 clamp.
- Sub-module adc_chan_pick: combinational next-set-bit finder. Inputs: mask, current index, from_start flag. Outputs: index and found. Instanced once.

Test Plan:
- Single sweep: mask=4'b0101, cfg0=16'h0009, cfg2=16'h0000, core model finishes 30 cycles after reset release with results 0x1B2 / 0x326; pulse trigger -> results (ch0,0x1B2) then (ch2,0x326). core_config_1_out=0x0009 during ch0 and 0x0000 during ch2. core_rst_n_out low exactly 2 cycles before each conversion. busy drops after ch2 CAPTURE+NEXT.
- Continuous: mask=4'b0001, period=200, ready always 1 -> result_valid pulses exactly every 200 cycles. With period=10 (shorter than conversion) -> sweeps back-to-back, no error flags.
- Overrun: mask=4'b0011, ready=0 -> second capture sets overrun_out=1 and result_chan_out=1. clear_err_in pulse -> overrun_out=0. Valid stays 1.
- Timeout: core never asserts finished -> timeout_out=1 after 2047 CONVERT cycles, no valid. Scheduler moves to next channel / IDLE.
- Abort: deassert enable_in mid-CONVERT -> core_rst_n_out=0 and busy_out=0 next cycle. Earlier unread result retained. Re-enable plus trigger restarts at the lowest slot.
- Reset mid-sweep: assert rst asynchronously between clock edges -> all outputs go to reset values immediately. mask=0 plus trigger -> stays IDLE.
